// File: rtl/mmb_read_sequencer.sv
// Bulk read controller: splits a (start address, word count) command into
// credit-limited mmb read bursts and streams the returned words out in order.
module mmb_read_sequencer #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int BWIDTH  = 4,
  parameter int LWIDTH  = 16,
  parameter int BURST   = 8,
  parameter int RDPENDS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [LWIDTH-1:0] cmd_len,
  input  logic              cmd_start,
  output logic              cmd_busy,
  output logic              done,
  output logic [DWIDTH-1:0] o_dat,
  output logic              o_val,
  output logic [AWIDTH-1:0] m_addr,
  output logic [BWIDTH-1:0] m_bcnt,
  output logic              m_wreq,
  output logic [DWIDTH-1:0] m_wdat,
  output logic              m_rreq,
  input  logic [DWIDTH-1:0] m_rdat,
  input  logic              m_rval,
  input  logic              m_busy
);

  localparam int CREDIT = RDPENDS * BURST;
  localparam int PWIDTH = $clog2(CREDIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state;
  state_t              state_next;
  logic [AWIDTH-1:0]   cur_addr;
  logic [LWIDTH-1:0]   issue_left;
  logic [LWIDTH-1:0]   rx_left;
  logic [PWIDTH-1:0]   pend_words;
  logic [PWIDTH-1:0]   pend_next;
  logic [LWIDTH-1:0]   burst_len;
  logic [PWIDTH:0]     credit_sum;
  logic                cmd_fire;
  logic                req_fire;
  logic                rx_fire;
  logic                final_word;

  assign burst_len  = (issue_left < LWIDTH'(BURST)) ? issue_left : LWIDTH'(BURST);
  assign m_bcnt     = BWIDTH'(burst_len);
  assign m_addr     = cur_addr;
  assign m_wreq     = 1'b0;
  assign m_wdat     = '0;
  assign cmd_busy   = (state != IDLE);

  // A request is only raised once the whole burst fits in the credit window,
  // so later returns can only keep it asserted while the slave stalls.
  assign credit_sum = {1'b0, pend_words} + (PWIDTH+1)'(m_bcnt);
  assign m_rreq     = (state == ISSUE) && (credit_sum <= (PWIDTH+1)'(CREDIT));

  assign cmd_fire   = cmd_start && (state == IDLE);
  assign req_fire   = m_rreq && !m_busy;
  assign rx_fire    = m_rval && (rx_left != '0);
  assign final_word = rx_fire && (rx_left == LWIDTH'(1));

  // NOTE: every signal written in an always_comb gets a default first so no
  // path can leave it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    pend_next  = pend_words;
    if (req_fire) pend_next = pend_next + PWIDTH'(burst_len);
    if (rx_fire)  pend_next = pend_next - PWIDTH'(1);
    case (state)
      IDLE:    if (cmd_fire && (cmd_len != '0)) state_next = ISSUE;
      ISSUE:   if (req_fire && (issue_left == burst_len)) state_next = DRAIN;
      DRAIN:   state_next = DRAIN;
      default: state_next = IDLE;
    endcase
    if (final_word) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_addr   <= '0;
      issue_left <= '0;
      rx_left    <= '0;
      pend_words <= '0;
      done       <= 1'b0;
      o_val      <= 1'b0;
      o_dat      <= '0;
    end else begin
      state      <= state_next;
      pend_words <= pend_next;
      done       <= final_word || (cmd_fire && (cmd_len == '0));
      o_val      <= rx_fire;
      if (rx_fire) o_dat <= m_rdat;
      if (cmd_fire) begin
        cur_addr   <= cmd_addr;
        issue_left <= cmd_len;
        rx_left    <= cmd_len;
      end else begin
        if (req_fire) begin
          cur_addr   <= cur_addr + AWIDTH'(burst_len);
          issue_left <= issue_left - burst_len;
        end
        if (rx_fire) rx_left <= rx_left - LWIDTH'(1);
      end
    end
  end

  a_req_hold: assert property (@(posedge clk) disable iff (reset)
    (m_rreq && m_busy) |=> (m_rreq && $stable(m_addr) && $stable(m_bcnt)));

  a_credit: assert property (@(posedge clk) disable iff (reset)
    pend_words <= PWIDTH'(CREDIT));

endmodule

// File: tb/tb_mmb_read_sequencer.sv
// Self-checking bench for mmb_read_sequencer: a responding slave, a command-level
// reference model, a vector table, hand-written corner sequences and random commands.
`timescale 1ns/1ps
module tb_mmb_read_sequencer;

  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int BW     = 4;
  localparam int LW     = 16;
  localparam int BURST  = 8;
  localparam int CREDIT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_start;
  logic          cmd_busy;
  logic          done;
  logic [DW-1:0] o_dat;
  logic          o_val;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_bcnt;
  logic          m_wreq;
  logic [DW-1:0] m_wdat;
  logic          m_rreq;
  logic [DW-1:0] m_rdat = '0;
  logic          m_rval = 1'b0;
  logic          m_busy = 1'b0;

  always #5 clk = ~clk;

  mmb_read_sequencer #(
    .AWIDTH(AW), .DWIDTH(DW), .BWIDTH(BW), .LWIDTH(LW), .BURST(BURST), .RDPENDS(2)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_start(cmd_start),
    .cmd_busy(cmd_busy), .done(done), .o_dat(o_dat), .o_val(o_val),
    .m_addr(m_addr), .m_bcnt(m_bcnt), .m_wreq(m_wreq), .m_wdat(m_wdat),
    .m_rreq(m_rreq), .m_rdat(m_rdat), .m_rval(m_rval), .m_busy(m_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return a ^ 8'hA5;
  endfunction

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] bcnt;
  } burst_t;

  // Reference model state: what the block owes, derived from commands only.
  int            cyc          = 0;
  int            rx_expect    = 0;
  int            pend_model   = 0;
  int            exp_done_cyc = -10;
  bit            oval_flag    = 1'b0;
  logic [AW-1:0] exp_addr_q[$];
  burst_t        exp_burst_q[$];

  // Slave state and statistics.
  logic [AW-1:0] wq[$];
  int            acc_cyc[$];
  int            ret_at_acc[$];
  int            n_acc       = 0;
  int            ret_total   = 0;
  int            done_count  = 0;
  int            stall_count = 0;
  int            busy_hold   = 0;
  bit            busy_rand   = 1'b0;
  bit            rval_rand   = 1'b0;
  bit            prev_stall  = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [BW-1:0] prev_bcnt;
  logic [AW-1:0] last_acc_addr;
  logic [BW-1:0] last_acc_bcnt;
  int            start_cyc   = 0;

  always @(negedge clk) begin
    logic [AW-1:0] w;
    burst_t        b;
    cyc++;

    check("o_val timing", o_val, oval_flag);
    check("done timing", done, (cyc == exp_done_cyc));
    if (done) done_count++;
    if (o_val && exp_addr_q.size() > 0) check("o_dat order", o_dat, word_of(exp_addr_q.pop_front()));
    oval_flag = 1'b0;

    if (prev_stall) begin
      check("stall m_rreq held", m_rreq, 1);
      check("stall m_addr held", m_addr, prev_addr);
      check("stall m_bcnt held", m_bcnt, prev_bcnt);
    end

    if (busy_hold > 0 && m_rreq) begin
      m_busy = 1'b1;
      busy_hold--;
    end else begin
      m_busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    prev_stall = m_rreq && m_busy;
    prev_addr  = m_addr;
    prev_bcnt  = m_bcnt;
    if (prev_stall) stall_count++;

    if (wq.size() > 0 && (!rval_rand || $urandom_range(0, 1) == 1)) begin
      w      = wq.pop_front();
      m_rval = 1'b1;
      m_rdat = word_of(w);
    end else begin
      m_rval = 1'b0;
      m_rdat = DW'($urandom);
    end

    if (m_rreq && !m_busy) begin
      check("m_wreq tied low", m_wreq, 0);
      check("m_wdat tied low", m_wdat, 0);
      check("credit limit", (pend_model + int'(m_bcnt) <= CREDIT), 1);
      if (exp_burst_q.size() == 0) begin
        check("unexpected m_rreq", m_rreq, 0);
      end else begin
        b = exp_burst_q.pop_front();
        check("burst addr", m_addr, b.addr);
        check("burst bcnt", m_bcnt, b.bcnt);
      end
      pend_model += int'(m_bcnt);
      n_acc++;
      acc_cyc.push_back(cyc);
      ret_at_acc.push_back(ret_total);
      last_acc_addr = m_addr;
      last_acc_bcnt = m_bcnt;
      for (int i = 0; i < int'(m_bcnt); i++) wq.push_back(m_addr + AW'(i));
    end

    if (m_rval && rx_expect > 0) begin
      rx_expect--;
      pend_model--;
      ret_total++;
      oval_flag = 1'b1;
      if (rx_expect == 0) exp_done_cyc = cyc + 1;
    end
  end

  task automatic start_cmd(input logic [AW-1:0] a, input logic [LW-1:0] len, output bit accepted);
    int            remaining;
    int            n;
    logic [AW-1:0] aa;
    @(negedge clk); #1;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_start = 1'b1;
    accepted  = !cmd_busy && !reset;
    if (accepted) begin
      start_cyc = cyc;
      rx_expect = int'(len);
      if (len == '0) exp_done_cyc = cyc + 1;
      remaining = int'(len);
      aa        = a;
      while (remaining > 0) begin
        n = (remaining < BURST) ? remaining : BURST;
        exp_burst_q.push_back('{aa, BW'(n)});
        aa        = aa + AW'(n);
        remaining = remaining - n;
      end
      for (int i = 0; i < int'(len); i++) exp_addr_q.push_back(a + AW'(i));
    end
    @(negedge clk); #1;
    cmd_start = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_len   = LW'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((cmd_busy || exp_addr_q.size() != 0 || cyc <= exp_done_cyc) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("completion within budget", (k < budget), 1);
    check("all bursts issued", exp_burst_q.size(), 0);
    check("cmd_busy low after done", cmd_busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset      = 1'b1;
    rx_expect  = 0;
    pend_model = 0;
    exp_addr_q.delete();
    exp_burst_q.delete();
    oval_flag    = 1'b0;
    exp_done_cyc = -10;
    prev_stall   = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    bit            brand;
    bit            rrand;
    int            nbursts;
    logic [AW-1:0] last_addr;
    logic [BW-1:0] last_bcnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit acc;
    int n0, d0, s0, i0, k;

    vecs[0] = '{8'h10, 16'd20, 1'b0, 1'b0, 3, 8'h20, 4'd4};
    vecs[1] = '{8'hFC, 16'd12, 1'b0, 1'b0, 2, 8'h04, 4'd4};
    vecs[2] = '{8'hF8, 16'd16, 1'b1, 1'b0, 2, 8'h00, 4'd8};
    vecs[3] = '{8'h00, 16'd1,  1'b0, 1'b1, 1, 8'h00, 4'd1};
    vecs[4] = '{8'h30, 16'd8,  1'b1, 1'b1, 1, 8'h30, 4'd8};
    vecs[5] = '{8'h80, 16'd9,  1'b0, 1'b1, 2, 8'h88, 4'd1};
    vecs[6] = '{8'h05, 16'd40, 1'b1, 1'b0, 5, 8'h25, 4'd8};
    vecs[7] = '{8'hF0, 16'd33, 1'b1, 1'b1, 5, 8'h10, 4'd1};

    reset     = 1'b1;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset cmd_busy", cmd_busy, 0);
    check("reset done", done, 0);
    check("reset o_val", o_val, 0);
    check("reset o_dat", o_dat, 0);
    check("reset m_rreq", m_rreq, 0);
    check("reset m_addr", m_addr, 0);
    check("reset m_bcnt", m_bcnt, 0);
    check("reset m_wreq", m_wreq, 0);
    check("reset m_wdat", m_wdat, 0);
    reset = 1'b0;

    // Split with credit throttling and exact cycle timing.
    i0 = acc_cyc.size();
    d0 = done_count;
    start_cmd(8'h10, 16'd20, acc);
    wait_done(500);
    check("split first req latency", acc_cyc[i0] - start_cyc, 1);
    check("split burst2 back-to-back", acc_cyc[i0+1] - acc_cyc[i0], 1);
    check("split burst3 after 4 returns", (ret_at_acc[i0+2] >= 4), 1);
    check("split burst3 cycle", acc_cyc[i0+2] - acc_cyc[i0], 5);
    check("split single done", done_count - d0, 1);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      busy_rand = vecs[i].brand;
      rval_rand = vecs[i].rrand;
      n0 = n_acc;
      d0 = done_count;
      start_cmd(vecs[i].addr, vecs[i].len, acc);
      wait_done(2000);
      check("vec burst count", n_acc - n0, vecs[i].nbursts);
      check("vec last burst addr", last_acc_addr, vecs[i].last_addr);
      check("vec last burst bcnt", last_acc_bcnt, vecs[i].last_bcnt);
      check("vec done count", done_count - d0, 1);
    end
    busy_rand = 1'b0;
    rval_rand = 1'b0;

    // Zero-length command.
    n0 = n_acc;
    d0 = done_count;
    start_cmd(8'h55, 16'd0, acc);
    check("zero-len cmd_busy", cmd_busy, 0);
    repeat (3) begin
      @(negedge clk); #1;
      check("zero-len cmd_busy stays low", cmd_busy, 0);
    end
    check("zero-len no request", n_acc - n0, 0);
    check("zero-len done count", done_count - d0, 1);

    // Slave stall on the first burst.
    n0 = n_acc;
    s0 = stall_count;
    busy_hold = 5;
    start_cmd(8'h60, 16'd8, acc);
    wait_done(500);
    check("stall cycles", stall_count - s0, 5);
    check("stall single burst", n_acc - n0, 1);

    // Reset mid-transfer, in-flight data discarded, then a fresh command.
    n0 = n_acc;
    d0 = done_count;
    start_cmd(8'h70, 16'd16, acc);
    k = 0;
    while (n_acc == n0 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    check("first burst before reset", (n_acc > n0), 1);
    do_reset();
    check("post-reset cmd_busy", cmd_busy, 0);
    check("post-reset o_val", o_val, 0);
    k = 0;
    while (wq.size() != 0 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check("stale words drained", wq.size(), 0);
    check("post-reset no done", done_count - d0, 0);
    check("post-reset still idle", cmd_busy, 0);
    start_cmd(8'h40, 16'd3, acc);
    wait_done(500);
    check("post-reset cmd done", done_count - d0, 1);
    check("post-reset last burst", last_acc_addr, 8'h40);

    // cmd_start while busy is ignored.
    n0 = n_acc;
    d0 = done_count;
    start_cmd(8'h90, 16'd20, acc);
    check("busy-test cmd_busy", cmd_busy, 1);
    start_cmd(8'h33, 16'd5, acc);
    start_cmd(8'hA0, 16'd0, acc);
    wait_done(500);
    check("busy-test burst count", n_acc - n0, 3);
    check("busy-test single done", done_count - d0, 1);

    // Random commands against the model.
    for (int i = 0; i < 25; i++) begin
      busy_rand = bit'($urandom_range(0, 1));
      rval_rand = bit'($urandom_range(0, 1));
      d0 = done_count;
      start_cmd(AW'($urandom), LW'($urandom_range(0, 50)), acc);
      wait_done(3000);
      check("random done count", done_count - d0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
